// File: rtl/neuron_accumulator.sv
// Signed multiply-accumulate front end for the sigmoid unit: streams (x, w) beats per vector,
// emits {addr, sign, ovf} in sign-magnitude form. Optional macro NEURON_BIAS_EN adds in_bias.
module neuron_accumulator #(
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 24,
    parameter int SHIFT     = 6,
    parameter int MAX_TERMS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_w,
    input  logic              in_last,
`ifdef NEURON_BIAS_EN
    input  logic [ACC_W-1:0]  in_bias,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [8:0]        out_addr,
    output logic              out_sign,
    output logic              out_ovf
);

    localparam int              CNT_W    = $clog2(MAX_TERMS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_TERMS - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ACC   = 3'd1;
    localparam logic [2:0] FLUSH = 3'd2;
    localparam logic [2:0] CONV  = 3'd3;
    localparam logic [2:0] OUT   = 3'd4;

    logic [2:0]               state_r;
    logic [2:0]               state_nx_s;
    logic [CNT_W-1:0]         cnt_r;
    logic                     in_ready_r;
    logic                     out_valid_r;
    logic [8:0]               out_addr_r;
    logic                     out_sign_r;
    logic                     out_ovf_r;
    logic                     accept_s;
    logic                     last_s;
    logic                     first_beat_s;
    logic signed [2*DATA_W-1:0] prod_s;
    logic signed [2*DATA_W-1:0] prod_r;
    logic                     prod_valid_r;
    logic                     prod_first_r;
    logic signed [ACC_W-1:0]  prod_ext_s;
    logic signed [ACC_W-1:0]  first_base_s;
    logic signed [ACC_W-1:0]  base_s;
    logic signed [ACC_W-1:0]  sum_s;
    logic signed [ACC_W-1:0]  acc_r;
    logic                     add_ovf_s;
    logic                     acc_ovf_r;
    logic [10:0]              conv_s;

    // Sign-magnitude conversion: {addr, sign, ovf}; the most negative value has no positive twin.
    function automatic logic [10:0] convert(input logic [ACC_W-1:0] acc, input logic sticky);
        logic [ACC_W-1:0] mag;
        logic [ACC_W-1:0] scaled;
        logic             is_min;
        logic             ovf;
        is_min = (acc == {1'b1, {(ACC_W-1){1'b0}}});
        if (acc[ACC_W-1]) begin
            mag = ~acc + {{(ACC_W-1){1'b0}}, 1'b1};
        end else begin
            mag = acc;
        end
        scaled = mag >> SHIFT;
        ovf    = sticky | is_min | (scaled > {{(ACC_W-9){1'b0}}, 9'h1FF});
        return {(ovf ? 9'h1FF : scaled[8:0]), acc[ACC_W-1], ovf};
    endfunction

    assign accept_s     = in_valid && in_ready_r;
    assign last_s       = in_last || (cnt_r == CNT_LAST);
    assign first_beat_s = (state_r == IDLE);
    assign prod_s       = $signed(in_x) * $signed(in_w);
    assign prod_ext_s   = {{(ACC_W-2*DATA_W){prod_r[2*DATA_W-1]}}, prod_r};
    assign sum_s        = base_s + prod_ext_s;
    assign add_ovf_s    = (base_s[ACC_W-1] == prod_ext_s[ACC_W-1]) &&
                          (sum_s[ACC_W-1] != base_s[ACC_W-1]);
    assign conv_s       = convert(acc_r, acc_ovf_r);

`ifdef NEURON_BIAS_EN
    logic signed [ACC_W-1:0] bias_r;

    // Bias rides along with the first beat so it is ready when that product lands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bias_r <= {ACC_W{1'b0}};
        end else if (accept_s && first_beat_s) begin
            bias_r <= in_bias;
        end else begin
            bias_r <= bias_r;
        end
    end

    assign first_base_s = bias_r;
`else
    assign first_base_s = {ACC_W{1'b0}};
`endif

    // Accumulator operand: restart from the bias (or zero) on the first product of a vector.
    always_comb begin
        base_s = acc_r;
        if (prod_first_r) begin
            base_s = first_base_s;
        end else begin
            base_s = acc_r;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE, ACC: begin
                if (accept_s) begin
                    state_nx_s = last_s ? FLUSH : ACC;
                end else begin
                    state_nx_s = state_r;
                end
            end
            FLUSH:   state_nx_s = CONV;
            CONV:    state_nx_s = OUT;
            OUT: begin
                if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = OUT;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State, registered in_ready and beat counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            in_ready_r <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_nx_s;
            in_ready_r <= (state_nx_s == IDLE) || (state_nx_s == ACC);
            if (accept_s) begin
                cnt_r <= last_s ? {CNT_W{1'b0}} : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Product stage followed by the accumulate with sticky signed-overflow tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_r       <= {(2*DATA_W){1'b0}};
            prod_valid_r <= 1'b0;
            prod_first_r <= 1'b0;
            acc_r        <= {ACC_W{1'b0}};
            acc_ovf_r    <= 1'b0;
        end else begin
            prod_r       <= accept_s ? prod_s : prod_r;
            prod_valid_r <= accept_s;
            prod_first_r <= accept_s && first_beat_s;
            if (prod_valid_r) begin
                acc_r     <= sum_s;
                acc_ovf_r <= prod_first_r ? add_ovf_s : (acc_ovf_r | add_ovf_s);
            end else begin
                acc_r     <= acc_r;
                acc_ovf_r <= acc_ovf_r;
            end
        end
    end

    // Result registers: loaded in CONV, held under backpressure, released on handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_addr_r  <= 9'h000;
            out_sign_r  <= 1'b0;
            out_ovf_r   <= 1'b0;
        end else if (state_r == CONV) begin
            out_valid_r <= 1'b1;
            out_addr_r  <= conv_s[10:2];
            out_sign_r  <= conv_s[1];
            out_ovf_r   <= conv_s[0];
        end else if ((state_r == OUT) && out_ready) begin
            out_valid_r <= 1'b0;
            out_addr_r  <= out_addr_r;
            out_sign_r  <= out_sign_r;
            out_ovf_r   <= out_ovf_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_addr_r  <= out_addr_r;
            out_sign_r  <= out_sign_r;
            out_ovf_r   <= out_ovf_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_addr  = out_addr_r;
    assign out_sign  = out_sign_r;
    assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Bench for neuron_accumulator: directed cases plus random vectors checked against an
// arithmetic model of the multiply-accumulate and sign-magnitude conversion.
module tb_neuron_accumulator;

    localparam longint MAXV = (longint'(1) <<< 23) - 1;
    localparam longint MINV = -(longint'(1) <<< 23);
    localparam longint SPAN = longint'(1) <<< 24;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_x;
    logic [7:0] in_w;
    logic       in_last;
`ifdef NEURON_BIAS_EN
    logic [23:0] in_bias;
`endif
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_addr;
    logic       out_sign;
    logic       out_ovf;

    int          vectors     = 0;
    int          miscompares = 0;
    longint      m_acc;
    bit          m_ovf;
    int          m_cnt;
    logic [10:0] exp_q[$];

    always #5 clk = ~clk;

    neuron_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .in_last   (in_last),
`ifdef NEURON_BIAS_EN
        .in_bias   (in_bias),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_sign  (out_sign),
        .out_ovf   (out_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint bias_value();
`ifdef NEURON_BIAS_EN
        return longint'($signed(in_bias));
`else
        return 64'sd0;
`endif
    endfunction

    // Expected {addr, sign, ovf} from a true integer sum.
    function automatic logic [10:0] model_conv(input longint acc, input bit sticky);
        longint     mag;
        bit         ovf;
        logic [8:0] a;
        mag = (acc < 0) ? -acc : acc;
        ovf = sticky || (acc == MINV) || ((mag / 64) > 511);
        a   = ovf ? 9'h1FF : 9'(mag / 64);
        return {a, (acc < 0), ovf};
    endfunction

    task automatic model_beat(input logic [7:0] x, input logic [7:0] w, input logic last,
                              output bit is_last);
        longint p;
        longint s;
        p = longint'($signed(x)) * longint'($signed(w));
        if (m_cnt == 0) begin
            s     = bias_value() + p;
            m_ovf = 1'b0;
        end else begin
            s = m_acc + p;
        end
        if (s > MAXV) begin
            s     = s - SPAN;
            m_ovf = 1'b1;
        end else if (s < MINV) begin
            s     = s + SPAN;
            m_ovf = 1'b1;
        end
        m_acc   = s;
        m_cnt   = m_cnt + 1;
        is_last = last || (m_cnt == 256);
        if (is_last) begin
            exp_q.push_back(model_conv(m_acc, m_ovf));
            m_cnt = 0;
        end
    endtask

    // Called and returns at a falling edge.
    task automatic send(input logic [7:0] x, input logic [7:0] w, input logic last,
                        output bit is_last);
        int n;
        in_x = x; in_w = w; in_last = last; in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", in_ready, 1);
        @(posedge clk);
        model_beat(x, w, last, is_last);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int hold);
        logic [10:0] e;
        logic [10:0] snap;
        int          n;
        out_ready = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7FF;
        chk({tag, "_addr"}, out_addr, e[10:2]);
        chk({tag, "_sign"}, out_sign, e[1]);
        chk({tag, "_ovf"}, out_ovf, e[0]);
        snap = {out_addr, out_sign, out_ovf};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold"}, {out_valid, out_addr, out_sign, out_ovf}, {1'b1, snap});
            chk({tag, "_busy"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_released"}, out_valid, 0);
        chk({tag, "_idle_ready"}, in_ready, 1);
    endtask

    initial begin
        bit lst;
        int len;
        rst_n = 1'b0; in_valid = 1'b0; in_x = 8'h00; in_w = 8'h00; in_last = 1'b0;
        out_ready = 1'b0;
`ifdef NEURON_BIAS_EN
        in_bias = 24'h000000;
`endif
        m_acc = 0; m_ovf = 1'b0; m_cnt = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_outs", {out_valid, out_addr, out_sign, out_ovf}, 12'h000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // 1: single beat 64*64, latency to out_valid
        send(8'd64, 8'd64, 1'b1, lst);
        chk("t1_flush", {out_valid, in_ready}, 2'b00);
        @(negedge clk);
        chk("t1_conv", {out_valid, in_ready}, 2'b00);
        @(negedge clk);
        chk("t1_out", out_valid, 1);
        chk("t1_addr_direct", out_addr, 9'd64);
        expect_result("t1", 0);

        // 2: (10,20),(-30,20) -> -400; in_ready low through result phase
        send(8'd10, 8'd20, 1'b0, lst);
        send(8'hE2, 8'd20, 1'b1, lst);
        chk("t2_flush_ready", in_ready, 0);
        expect_result("t2", 2);

        // 3: 40 x (127,127) -> magnitude overflow
        for (int i = 0; i < 40; i++) send(8'd127, 8'd127, (i == 39), lst);
        expect_result("t3", 0);

        // 4: backpressure with in_valid asserted, then next beat right after release
        send(8'd3, 8'd5, 1'b1, lst);
        in_x = 8'd7; in_w = 8'hF9; in_last = 1'b1; in_valid = 1'b1;
        expect_result("t4", 5);
        send(8'd7, 8'hF9, 1'b1, lst);
        expect_result("t4_next", 0);

        // 5: 256 beats without in_last, then a new vector
        for (int i = 0; i < 256; i++) send(8'd1, 8'd1, 1'b0, lst);
        chk("t5_forced_last", lst, 1);
        expect_result("t5", 0);
        send(8'd1, 8'd1, 1'b1, lst);
        expect_result("t5_new", 0);

        // 6: reset mid-vector discards partial sum
        for (int i = 0; i < 3; i++) send(8'd100, 8'd100, 1'b0, lst);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_ready", in_ready, 0);
        rst_n = 1'b1;
        m_cnt = 0;
        exp_q.delete();
        @(negedge clk);
`ifdef NEURON_BIAS_EN
        in_bias = -24'sd4096;
`endif
        send(8'd64, 8'd64, 1'b1, lst);
        expect_result("t6", 0);

        // Random vectors
        for (int v = 0; v < 30; v++) begin
            len = int'($urandom_range(1, 12));
`ifdef NEURON_BIAS_EN
            in_bias = 24'($urandom);
`endif
            for (int i = 0; i < len; i++) begin
                send(8'($urandom), 8'($urandom), (i == len - 1), lst);
            end
            expect_result("rnd", int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
